// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and FSM state encoding for the shift-add multiplier
package mult_pkg;

  localparam int N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/mult_control_claa.sv
// rtl/mult_control_claa.sv - 4-bit carry-lookahead adder CLAA_1 with group generate/propagate
module CLAA_1 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout,
  output logic       Gij,
  output logic       Pij
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Carries expanded in two-level form rather than rippled.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = Gij | (Pij & Cin);

  assign Gij  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign Pij  = &p;
  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/mult_control.sv
// rtl/mult_control.sv - unsigned shift-add multiplier, fixed 2N-cycle latency, product in {A,MQ}
module mult_control
  import mult_pkg::*;
#(
  parameter int N = mult_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] A,
  output logic [N-1:0] MQ,
  output logic         busy,
  output logic         done
);

  state_t       state;
  logic [N-1:0] M;
  logic         C;
  logic [1:0]   count;

  logic [N-1:0] addend;
  logic [N-1:0] sum;
  logic         sum_cout;
  logic         claa_g_unused;
  logic         claa_p_unused;

  // The add happens every iteration (adding zero when MQ[0]=0) so latency never varies.
  assign addend = MQ[0] ? M : '0;

  CLAA_1 u_claa (
    .A    (A),
    .B    (addend),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (sum_cout),
    .Gij  (claa_g_unused),
    .Pij  (claa_p_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      A     <= '0;
      MQ    <= '0;
      M     <= '0;
      C     <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            A     <= '0;
            C     <= 1'b0;
            M     <= x;
            MQ    <= y;
            count <= '0;
            state <= ADD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ADD: begin
          A     <= sum;
          C     <= sum_cout;
          state <= SHIFT;
        end
        SHIFT: begin
          // Carry enters A's MSB here, so the final shift leaves C clear.
          {C, A, MQ} <= {1'b0, C, A, MQ[N-1:1]};
          count      <= count + 2'd1;
          if (count == 2'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - directed and randomized self-checking bench for mult_control
module tb_mult_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [3:0] a;
  logic [3:0] mq;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  mult_control #(.N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .x    (x),
    .y    (y),
    .A    (a),
    .MQ   (mq),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect 8 busy cycles; optionally scramble x/y and pulse load while busy.
  task automatic wait_busy(input string tag, input bit disturb);
    for (int i = 0; i < 8; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " done_low"}, {31'd0, done}, 32'd0);
      if (disturb) begin
        x    = 4'($urandom);
        y    = 4'($urandom);
        load = 1'($urandom);
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic check_result(input string tag, input int px, input int py);
    int prod;
    prod = px * py;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, " product"}, {24'd0, a, mq}, 32'(prod));
  endtask

  task automatic run_op(input string tag, input int px, input int py, input bit disturb);
    load = 1'b1;
    x    = 4'(px);
    y    = 4'(py);
    @(negedge clk);
    load = 1'b0;
    wait_busy(tag, disturb);
    check_result(tag, px, py);
  endtask

  initial begin
    int rx;
    int ry;
    int done_cycles;

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset A", {28'd0, a}, 32'd0);
    chk("reset MQ", {28'd0, mq}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("idle hold", {26'd0, a, mq, busy, done}, 32'd0);

    run_op("15x15", 15, 15, 1'b0);
    run_op("13x11", 13, 11, 1'b0);
    run_op("0x9", 0, 9, 1'b0);

    // Load pulse with new operands at cycle 3 of a running operation must be ignored.
    load = 1'b1; x = 4'd3; y = 4'd5;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; x = 4'd15; y = 4'd15;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check_result("ignored_load", 3, 5);

    // Result must hold in DONE while load stays low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_result("done_hold", 3, 5);
    end

    // Reset mid-operation aborts with nothing retained.
    load = 1'b1; x = 4'd9; y = 4'd7;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outs", {26'd0, a, mq, busy, done}, 32'd0);
    done_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cycles++;
    end
    chk("abort no_done", 32'(done_cycles), 32'd0);
    chk("abort idle outs", {26'd0, a, mq, busy, done}, 32'd0);

    // Load held high: back-to-back restarts, done lasts one cycle per result.
    load = 1'b1; x = 4'd7; y = 4'd9;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b busy", {31'd0, busy}, 32'd1);
        chk("b2b done_low", {31'd0, done}, 32'd0);
        @(negedge clk);
      end
      check_result("b2b", 7, 9);
      @(negedge clk);
    end
    load = 1'b0;
    wait_busy("b2b_last", 1'b0);
    check_result("b2b_last", 7, 9);

    // Randomized operands, with operands and load scrambled while busy.
    for (int n = 0; n < 8; n++) begin
      rx = int'($urandom_range(0, 15));
      ry = int'($urandom_range(0, 15));
      if (n == 0) begin
        rx = 15;
        ry = 0;
      end
      run_op("random", rx, ry, 1'b1);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (busy && done) begin
      failures++;
      $display("FAIL busy_done_exclusive observed=11 expected=not_both");
    end
  end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand width; only N=4 is supported, to match the 4-bit CLA adder.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit: start request, sampled on the rising edge of clk.
REQ-005 SHALL have port x, input, N bits: multiplicand, unsigned.
REQ-006 SHALL have port y, input, N bits: multiplier, unsigned.
REQ-007 SHALL have port A, output, N bits: accumulator, the upper half of the product.
REQ-008 SHALL have port MQ, output, N bits: multiplier/quotient register, the lower half of the product.
REQ-009 SHALL have port busy, output, 1 bit: high while in ADD or SHIFT.
REQ-010 SHALL have port done, output, 1 bit: high while in DONE; product {A,MQ} is valid.

Function
REQ-011 SHALL implement an unsigned shift-add multiplier with internal registers M (N bits), C (carry, 1 bit) and count (2 bits).
REQ-012 SHALL use a four-state FSM: IDLE, ADD, SHIFT, DONE.
REQ-013 SHALL, in IDLE or DONE with load=1, load A<=0, C<=0, M<=x, MQ<=y, count<=0, then enter ADD.
REQ-014 SHALL, in IDLE with load=0, hold all registers.
REQ-015 SHALL, in DONE with load=0, hold A and MQ.
REQ-016 SHALL, in ADD, compute {C,A} <= A + (MQ[0] ? M : 0) with carry-in 0, then enter SHIFT.
REQ-017 SHALL perform the ADD step every iteration regardless of MQ[0], so latency is fixed.
REQ-018 SHALL, in SHIFT, right-shift {C,A,MQ} by one with C<=0 and count<=count+1.
REQ-019 SHALL, after SHIFT, enter DONE if count was N-1 before the increment, else return to ADD.
REQ-020 SHALL have a latency of exactly 2N rising edges (8 for N=4) from the edge sampling load to the edge entering DONE; done is first high in the following cycle.
REQ-021 SHALL ignore load while busy=1; the operation in progress is unaffected.
REQ-022 SHALL support back-to-back operation: load=1 while in DONE starts a new operation on that edge, and done deasserts in the next cycle.
REQ-023 SHALL never assert busy and done together.
REQ-024 SHALL never let the final product {A,MQ} exceed 2N bits; the carry C is absorbed by the last SHIFT.
REQ-025 SHALL sample x and y only on the load edge; changes to them during busy have no effect.

Reset
REQ-026 SHALL, when rst=1 on a clock edge, set state=IDLE, A=0, MQ=0, M=0, C=0, count=0, busy=0 and done=0.
REQ-027 SHALL give rst priority over load.
REQ-028 SHALL abort any operation in progress on rst, with no partial product retained.
REQ-029 SHALL drive defined (non-X) values on all outputs from the first edge with rst=1.

Structure
REQ-030 SHALL take the state encoding (IDLE=2'b00, ADD=2'b01, SHIFT=2'b10, DONE=2'b11) and the constant N from shared package mult_pkg.
REQ-031 SHALL instantiate the existing 4-bit carry-lookahead adder CLAA_1 exactly once as the ADD-step adder.
REQ-032 SHALL connect CLAA_1 with Cin=0 and take C from its Cout; Gij and Pij are left unused.
REQ-033 SHALL keep the FSM and datapath registers in a single always block clocked by clk; no other sub-modules are used.

Verification
REQ-034 SHALL cover: rst=1 for 2 cycles, then idle -> A=0, MQ=0, busy=0, done=0.
REQ-035 SHALL cover: load with x=15, y=15 -> busy for 8 cycles, then done=1 with A=4'hE, MQ=4'h1 (225).
REQ-036 SHALL cover: load with x=13, y=11 -> A=4'h8, MQ=4'hF (143); also x=0, y=9 -> A=0, MQ=0 with the same 8-cycle latency.
REQ-037 SHALL cover: load with x=3, y=5, then load pulsed with x=15, y=15 at cycle 3 -> ignored, result A=0, MQ=4'hF (15).
REQ-038 SHALL cover: rst=1 at cycle 4 of an operation -> next cycle state=IDLE, outputs all zero, done never asserts.
REQ-039 SHALL cover: load held high continuously -> a new operation restarts each time DONE is reached, and done is high for exactly one cycle per result.
